// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types and widths for the APB bridge arbiter
package apb_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_t;
  typedef logic req_id_t;
endpackage

// File: rtl/apb_bridge_arbiter_if.sv
// apb_bridge_arbiter_if: requester command/response and APB master signals
interface apb_bridge_arbiter_if;
  import apb_arb_pkg::*;
  logic              req0_valid, req0_write, req0_ready, req0_done, req0_err;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_write, req1_ready, req1_done, req1_err;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              PSELx, PENABLE, PWRITE, PREADY;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              busy;
  req_id_t           grant_id;
  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, req0_done, req0_err, req0_rdata,
    output req1_ready, req1_done, req1_err, req1_rdata,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA,
    output busy, grant_id
  );
  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, req0_done, req0_err, req0_rdata,
    input  req1_ready, req1_done, req1_err, req1_rdata,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA,
    input  busy, grant_id
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant; on a tie the requester not granted last wins
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic       gnt_valid,
  output req_id_t    gnt
);
  assign gnt_valid = |valid;
  assign gnt       = &valid ? ~last : valid[1];
endmodule

// File: rtl/apb_bridge_arbiter.sv
// apb_bridge_arbiter: round-robin sharing of one APB master port between two requesters
module apb_bridge_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  PCLK,
  input logic                  PRESETn,
  apb_bridge_arbiter_if.master bus
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  arb_state_t                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  req_id_t                      last_q, last_d, gid_q, gid_d;
  logic                         psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]            paddr_q, paddr_d;
  logic [DATA_W-1:0]            pwdata_q, pwdata_d;
  logic [1:0]                   done_q, done_d, err_q, err_d;
  logic [1:0][DATA_W-1:0]       rdata_q, rdata_d;
  logic [1:0]                   elig;
  logic                         gnt_valid;
  req_id_t                      gnt;

  // a requester whose done is showing this cycle sits out so it cannot be re-accepted at once
  assign elig = {bus.req1_valid, bus.req0_valid} & ~done_q & {2{PRESETn && state_q == IDLE}};

  rr_arb2 u_rr (.valid(elig), .last(last_q), .gnt_valid(gnt_valid), .gnt(gnt));

  assign bus.req0_ready = gnt_valid & ~gnt;
  assign bus.req1_ready = gnt_valid & gnt;
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.PSELx      = psel_q;
  assign bus.PENABLE    = pen_q;
  assign bus.PWRITE     = pwrite_q;
  assign bus.PADDR      = paddr_q;
  assign bus.PWDATA     = pwdata_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.grant_id   = gid_q;

  // next-state: accept and latch a command, walk SETUP/ACCESS, finish on PREADY or timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gid_d    = gid_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    done_d   = '0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: if (gnt_valid) begin
        state_d  = SETUP;
        cnt_d    = '0;
        last_d   = gnt;
        gid_d    = gnt;
        pwrite_d = gnt ? bus.req1_write : bus.req0_write;
        paddr_d  = gnt ? bus.req1_addr  : bus.req0_addr;
        pwdata_d = gnt ? bus.req1_wdata : bus.req0_wdata;
      end
      SETUP: state_d = ACCESS;
      ACCESS: if (bus.PREADY) begin
        state_d        = IDLE;
        done_d[gid_q]  = 1'b1;
        err_d[gid_q]   = 1'b0;
        rdata_d[gid_q] = pwrite_q ? '0 : bus.PRDATA;
      end else if (TIMEOUT_CYCLES != 0 && cnt_q == TMAX) begin
        state_d        = IDLE;
        done_d[gid_q]  = 1'b1;
        err_d[gid_q]   = 1'b1;
        rdata_d[gid_q] = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
    psel_d = state_d != IDLE;
    pen_d  = state_d == ACCESS;
  end

  // state and registered outputs; reset abandons any transfer in flight
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      psel_q   <= psel_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// tb_apb_bridge_arbiter: directed stimulus with a completion scoreboard and APB monitor
module tb_apb_bridge_arbiter;
  typedef struct packed {
    logic        id;
    logic        err;
    logic [7:0]  rdata;
    logic [31:0] due;
  } exp_t;

  logic        pclk = 0;
  logic        presetn = 0;
  logic [31:0] cyc = 0;
  logic [16:0] exp_cmd = '0;
  exp_t        sb[$];
  exp_t        e;
  int          passed = 0;
  int          total = 0;
  logic        act_id, act_err;
  logic [7:0]  act_rd;

  apb_bridge_arbiter_if bus ();
  apb_bridge_arbiter #(.TIMEOUT_CYCLES(4)) dut (.PCLK(pclk), .PRESETn(presetn), .bus(bus));

  assign bus.PRDATA = bus.PADDR ^ 8'h38;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic drive(input logic id, input logic wr, input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      bus.req1_valid = 1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
    end else begin
      bus.req0_valid = 1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
    end
  endtask

  task automatic expect_done(input logic id, input logic err, input logic [7:0] rd, input int lat);
    exp_t x;
    x.id = id; x.err = err; x.rdata = rd; x.due = cyc + 32'(lat);
    sb.push_back(x);
  endtask

  task automatic check_ready(input logic [1:0] ex);
    #1;
    check("ready", {bus.req1_ready, bus.req0_ready}, ex);
  endtask

  // monitor: APB command held while selected, completions popped from the scoreboard
  always @(negedge pclk) begin
    if (bus.PSELx) check("apb_cmd", {bus.PADDR, bus.PWDATA, bus.PWRITE}, exp_cmd);
    if (bus.req0_done || bus.req1_done) begin
      act_id  = bus.req1_done;
      act_err = act_id ? bus.req1_err : bus.req0_err;
      act_rd  = act_id ? bus.req1_rdata : bus.req0_rdata;
      if (sb.size() == 0) check("done_unexpected", {act_id, bus.req1_done, bus.req0_done}, 0);
      else begin
        e = sb.pop_front();
        check("done", {bus.req1_done & bus.req0_done, act_id, act_err, act_rd, cyc}, {1'b0, e.id, e.err, e.rdata, e.due});
      end
      check("done_vs_ready", (bus.req0_done & bus.req0_ready) | (bus.req1_done & bus.req1_ready), 0);
    end
  end

  initial begin
    bus.PREADY = 1;
    bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
    tick(2);
    check("rst_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
    check("rst_stat", {bus.busy, bus.grant_id, bus.req0_done, bus.req0_err, bus.req1_done, bus.req1_err}, 0);
    check("rst_rdata", {bus.req0_rdata, bus.req1_rdata}, 0);
    bus.req0_valid = 1;
    check_ready(2'b00);
    bus.req0_valid = 0;
    tick(1);
    presetn = 1;
    tick(1);
    // single zero-wait write
    drive(0, 1, 8'h02, 8'hA5); exp_cmd = {8'h02, 8'hA5, 1'b1}; expect_done(0, 0, 8'h00, 3);
    check_ready(2'b01);
    tick(1); bus.req0_valid = 0;
    check("w_setup", {bus.PSELx, bus.PENABLE, bus.busy, bus.grant_id}, 4'b1010);
    tick(1);
    check("w_access", {bus.PSELx, bus.PENABLE}, 2'b11);
    tick(1);
    check("w_idle", {bus.PSELx, bus.PENABLE, bus.busy}, 0);
    // read with three wait states
    bus.PREADY = 0;
    drive(1, 0, 8'h04, 8'h00); exp_cmd = {8'h04, 8'h00, 1'b0}; expect_done(1, 0, 8'h3C, 6);
    check_ready(2'b10);
    tick(1); bus.req1_valid = 0;
    check("r_setup", {bus.PSELx, bus.PENABLE, bus.grant_id}, 3'b101);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("r_wait", {bus.PSELx, bus.PENABLE}, 2'b11);
    end
    tick(1); bus.PREADY = 1;
    tick(1);
    check("r_end", bus.PSELx, 0);
    // contention: both held valid for four transfers
    drive(0, 0, 8'h10, 8'h00);
    drive(1, 0, 8'h11, 8'h00);
    for (int k = 0; k < 4; k++) begin
      exp_cmd = {k[0] ? 8'h11 : 8'h10, 8'h00, 1'b0};
      expect_done(k[0], 0, k[0] ? 8'h29 : 8'h28, 3);
      check_ready(k[0] ? 2'b10 : 2'b01);
      if (k < 3) tick(3);
    end
    tick(1); bus.req0_valid = 0; bus.req1_valid = 0;
    tick(3);
    // timeout with PREADY stuck low, then a normal read
    bus.PREADY = 0;
    drive(0, 1, 8'h20, 8'h11); exp_cmd = {8'h20, 8'h11, 1'b1}; expect_done(0, 1, 8'h00, 7);
    check_ready(2'b01);
    tick(1); bus.req0_valid = 0;
    tick(5);
    check("to_last", {bus.PSELx, bus.PENABLE}, 2'b11);
    tick(1);
    check("to_drop", {bus.PSELx, bus.PENABLE, bus.busy}, 0);
    bus.PREADY = 1;
    tick(1);
    drive(0, 0, 8'h21, 8'h00); exp_cmd = {8'h21, 8'h00, 1'b0}; expect_done(0, 0, 8'h19, 3);
    check_ready(2'b01);
    tick(1); bus.req0_valid = 0;
    tick(3);
    // reset during ACCESS abandons the transfer
    bus.PREADY = 0;
    drive(1, 1, 8'h40, 8'h99); exp_cmd = {8'h40, 8'h99, 1'b1};
    check_ready(2'b10);
    tick(1); bus.req1_valid = 0;
    tick(1);
    check("rm_access", {bus.PSELx, bus.PENABLE}, 2'b11);
    presetn = 0;
    tick(1);
    check("rm_apb", {bus.PSELx, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
    check("rm_stat", {bus.busy, bus.grant_id, bus.req0_done, bus.req1_done}, 0);
    presetn = 1; bus.PREADY = 1;
    drive(0, 0, 8'h50, 8'h00);
    drive(1, 0, 8'h51, 8'h00);
    exp_cmd = {8'h50, 8'h00, 1'b0}; expect_done(0, 0, 8'h68, 3);
    check_ready(2'b01);
    tick(3);
    exp_cmd = {8'h51, 8'h00, 1'b0}; expect_done(1, 0, 8'h69, 3);
    check_ready(2'b10);
    tick(1); bus.req0_valid = 0; bus.req1_valid = 0;
    tick(4);
    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/apb_bridge_arbiter.md
# apb_bridge_arbiter

Two-requester arbiter and APB master sequencer that shares the single APB slave port of the I2C-APB bridge between two on-chip requesters (e.g. a firmware register path and a DMA/sequencer path). It accepts one register read/write command at a time, arbitrates round-robin, and runs a full APB SETUP/ACCESS transfer into the bridge. It returns read data and completion status to the winning requester, and aborts with an error if the slave never asserts PREADY.

## Interface
- TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles waiting for PREADY; 0 disables the timeout.

- PCLK  in  1  clock; all logic on the rising edge
- PRESETn  in  1  synchronous active-low reset
- reqN_valid  in  1  requester N (N=0,1) has a command pending
- reqN_write  in  1  1 = APB write, 0 = APB read
- reqN_addr  in  8  target PADDR
- reqN_wdata  in  8  write data (ignored for reads)
- reqN_ready  out  1  command accepted this cycle (valid&ready handshake)
- reqN_done  out  1  one-cycle completion pulse
- reqN_err  out  1  qualifies reqN_done: 1 = timeout abort
- reqN_rdata  out  8  read data, valid while reqN_done=1
- PSELx, PENABLE, PWRITE  out  1 each  APB master controls to the bridge
- PADDR, PWDATA  out  8 each  APB address/write data
- PREADY  in  1  APB slave ready
- PRDATA  in  8  APB read data
- busy  out  1  state != IDLE
- grant_id  out  1  requester owning the current/last transfer

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: if any reqN_valid, grant per round-robin and raise reqN_ready combinationally for the winner only. At the edge: latch write/addr/wdata, set grant_id, update last-grant pointer, go to SETUP.
- Round-robin: if only one valid, grant it. If both are valid, grant the one not granted last. The pointer resets to 1, so requester 0 wins the first tie.
- SETUP: PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched command; go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1, with the same address/data held.
  - PREADY=1 at an edge: capture PRDATA (writes capture 0), pulse done for the owner next cycle with err=0, go to IDLE.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT_CYCLES, drop PSELx/PENABLE, pulse done with err=1 and rdata=0, go to IDLE.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It clears on entry to SETUP.
- Requesters hold valid and their fields stable until ready. Deasserting valid before ready is legal and issues nothing.
- A done pulse never coincides with the same requester's ready. The other requester may be granted in the done cycle.
- reqN_rdata/err hold their value after done until that requester's next done.

## Timing
- Reset (PRESETn low at an edge) drives:
  - state=IDLE; PSELx=PENABLE=PWRITE=0; PADDR=PWDATA=0
  - reqN_done=reqN_err=0; reqN_rdata=0; busy=0; grant_id=0; pointer=1
- reqN_ready is gated low while PRESETn=0.
- Reset mid-transfer abandons it: no done pulse, and APB signals drop on that edge.
- All outputs are registered except reqN_ready.
- Zero-wait-state transfer: accept in cycle T, SETUP in T+1, ACCESS in T+2 (PREADY=1), done/IDLE in T+3. The next accept is possible in T+3, so back-to-back throughput is one transfer per 3 cycles.
- Each PREADY wait cycle adds one cycle.
- Timeout: done/err appears TIMEOUT_CYCLES+1 cycles after ACCESS entry.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle (APB rule).

## Structure
- Package apb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_t
  - typedef logic req_id_t
  - localparams for APB address and data width (8)
- Sub-module rr_arb2: two-input round-robin grant from valid bits and the last-grant pointer. It is combinational grant logic, with the pointer register kept in the parent.

## Test plan
- Single write: req0 write addr 0x02 data 0xA5, PREADY tied 1 → ready T0, PSELx T1, PENABLE T2 with PADDR=0x02/PWDATA=0xA5/PWRITE=1, req0_done=1/err=0 at T3.
- Read with wait states: req1 read 0x04, PREADY low for 3 ACCESS cycles then high with PRDATA=0x3C → req1_done at T6, rdata=0x3C, address stable throughout.
- Contention: both valid continuously for 4 transfers → grant order 0,1,0,1; each done goes only to its owner.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 → PSELx drops and req0_done=1/err=1/rdata=0 five cycles after ACCESS entry; the next request proceeds normally.
- Reset mid-ACCESS: PRESETn low for one edge during ACCESS → all outputs 0 next cycle, no done pulse; after release req0 wins the first tie.
